// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling line-buffer read path.
//   - rd_state_e : read sequencer FSM states (IDLE / READ / DRAIN)
//   - RD_LAT     : BRAM read latency in cycles, from bram_en to bram_rdata
//   - FIFO_DEPTH : output FIFO depth, RD_LAT + 2
//   - CNT_W      : width of a 0..FIFO_DEPTH occupancy count
// Build option: BRAM_OUTREG_EN
//   defined   -> BRAM output register in use, RD_LAT = 2, FIFO_DEPTH = 4
//   undefined -> RD_LAT = 1, FIFO_DEPTH = 3
// ---------------------------------------------------------------------------
package pool_pkg;

`ifdef BRAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // Two entries beyond the read latency let the burst run at one word per
    // cycle while still bounding storage under any backpressure pattern.
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pool_rd_fifo.sv
// ---------------------------------------------------------------------------
// pool_rd_fifo
// Small register FIFO that absorbs BRAM read data ahead of the valid/ready
// output. The head entry is presented combinationally on head_data.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write one entry (caller guarantees not full)
//   pop             remove head entry (caller guarantees not empty)
//   head_data       current head entry
//   count           number of stored entries, 0..DEPTH
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module pool_rd_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately left without reset; the occupancy count
    // is reset, and the consumer masks the head whenever the FIFO is empty,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/pool_bram_reader.sv
// ---------------------------------------------------------------------------
// pool_bram_reader
// Read-side sequencer for the pooling line-buffer BRAM. A start request
// launches a contiguous (wrapping) burst of BRAM reads; returned words are
// buffered and streamed on a valid/ready interface without loss.
// Build option: BRAM_OUTREG_EN selects a 2-cycle BRAM read latency
// (see pool_pkg); default is 1 cycle.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start            burst request, sampled only when idle
//   start_addr, len  first address and word count (0..SRAM_DEPTH)
//   bram_en/addr     BRAM read port controls
//   bram_rdata       BRAM data, valid RD_LAT cycles after bram_en
//   m_valid/m_ready  output handshake; m_data word, m_last final word
//   busy             burst in progress
//   done             one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module pool_bram_reader
    import pool_pkg::*;
#(
    parameter  int SRAM_DEPTH = 1024,
    parameter  int DATA_WIDTH = 8,
    localparam int AW         = $clog2(SRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         start_addr,
    input  logic [AW:0]           len,
    output logic                  bram_en,
    output logic [AW-1:0]         bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    rd_state_e         state_q;
    logic [AW-1:0]     addr_q;       // next address to issue
    logic [AW-1:0]     last_addr_q;  // last issued address, shown while idle
    logic [AW:0]       remaining_q;
    logic [RD_LAT-1:0] pipe_vld_q;   // reads in flight inside the BRAM
    logic [RD_LAT-1:0] pipe_last_q;
    logic              done_q;

    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    inflight_cnt;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_WIDTH:0] head;

    // NOTE: every signal driven in always_comb receives a default before any
    // conditional logic, so no path can leave it holding a value (latch).
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + (CNT_W + 1)'(pipe_vld_q[i]);
        end
    end

    // Credit rule: every word in flight or buffered owns a FIFO slot, so
    // the FIFO cannot overflow however long m_ready stays low.
    assign issue = (state_q == ST_READ) && (remaining_q != '0) &&
                   (({1'b0, fifo_count} + inflight_cnt) < (CNT_W + 1)'(FIFO_DEPTH));

    assign push = pipe_vld_q[RD_LAT-1];
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && (remaining_q == (AW + 1)'(1));
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end

            if (issue) begin
                addr_q      <= addr_q + 1'b1;  // natural wrap at SRAM_DEPTH
                last_addr_q <= addr_q;
                remaining_q <= remaining_q - 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state_q     <= ST_READ;
                            addr_q      <= start_addr;
                            remaining_q <= len;
                        end else begin
                            done_q <= 1'b1;  // empty burst completes at once
                        end
                    end
                end
                ST_READ: begin
                    if (issue && (remaining_q == (AW + 1)'(1))) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && head[DATA_WIDTH]) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pool_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pipe_last_q[RD_LAT-1], bram_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) assert (!(push && fifo_full && !pop));
    end

    assign bram_en   = issue;
    assign bram_addr = issue ? addr_q : last_addr_q;
    assign m_valid   = !fifo_empty;
    assign m_data    = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_last    = m_valid && head[DATA_WIDTH];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_pool_bram_reader.sv
// ---------------------------------------------------------------------------
// tb_pool_bram_reader
// Scoreboard bench for pool_bram_reader: a BRAM model with BRAM[i]=i+16,
// expected addresses and beats queued at start, a monitor comparing reads,
// beats and stall stability on every falling edge.
// ---------------------------------------------------------------------------
module tb_pool_bram_reader;

`ifdef BRAM_OUTREG_EN
    localparam int TB_RD_LAT = 2;
`else
    localparam int TB_RD_LAT = 1;
`endif
    localparam int TB_D = TB_RD_LAT + 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] len;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [7:0]  bram_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    pool_bram_reader #(
        .SRAM_DEPTH (1024),
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model
    logic [7:0] mem [1024];
    logic [7:0] s1, s2;
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 16);
    always @(posedge clk) begin
        if (bram_en) s1 <= mem[bram_addr];
        s2 <= s1;
    end
    assign bram_rdata = (TB_RD_LAT == 2) ? s2 : s1;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_addr_q [$];
    logic [8:0] exp_beat_q [$];
    int         out_cnt = 0;
    int         max_out = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                out_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (bram_en) begin
                    if (exp_addr_q.size() == 0) check("read_unexpected", 32'(bram_addr), 32'hFFFF_FFFF);
                    else check("rd_addr", 32'(bram_addr), 32'(exp_addr_q.pop_front()));
                end
                if (prev_stall)
                    check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_beat}));
                if (m_valid && m_ready) begin
                    if (exp_beat_q.size() == 0) check("beat_unexpected", 32'({m_last, m_data}), 32'hFFFF_FFFF);
                    else check("beat", 32'({m_last, m_data}), 32'(exp_beat_q.pop_front()));
                end
                out_cnt += int'(bram_en);
                if (out_cnt > max_out) max_out = out_cnt;
                if (m_valid && m_ready) out_cnt--;
                prev_stall = m_valid && !m_ready;
                prev_beat  = {m_last, m_data};
            end
        end
    end

    // Queue the expected reads and beats, then present start for one edge.
    task automatic start_burst(input int a, input int n);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = 10'(a);
        len        = 11'(n);
        for (int k = 0; k < n; k++) begin
            exp_addr_q.push_back(10'((a + k) % 1024));
            exp_beat_q.push_back({k == n - 1, 8'(((a + k) % 1024) + 16)});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic capture(input int ncyc, output logic [15:0] en_m, output logic [15:0] v_m,
                           output logic [15:0] b_m, output logic [15:0] d_m);
        en_m = '0; v_m = '0; b_m = '0; d_m = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            en_m[c] = bram_en;
            v_m[c]  = m_valid;
            b_m[c]  = busy;
            d_m[c]  = done;
        end
    endtask

    task automatic run_burst(input string tag, input int a, input int n, input logic [31:0] pat,
                             input int poke_cyc, input int exp_cyc);
        int got_cyc;
        got_cyc = 0;
        m_ready = pat[0];
        start_burst(a, n);
        for (int i = 1; i <= n + 200; i++) begin
            @(negedge clk);
            if (done) begin
                got_cyc = i;
                break;
            end
            @(posedge clk); #1;
            m_ready = pat[i % 32];
            if (i == poke_cyc) begin
                start      = 1'b1;
                start_addr = 10'd500;
                len        = 11'd3;
            end else begin
                start = 1'b0;
            end
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check({tag, "_done_seen"}, 32'(got_cyc != 0), 32'd1);
        if (exp_cyc != 0) check({tag, "_done_cycle"}, 32'(got_cyc), 32'(exp_cyc));
        repeat (2) @(negedge clk);
        check({tag, "_beats_left"}, 32'(exp_beat_q.size()), 32'd0);
        check({tag, "_reads_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    logic [15:0] en_m, v_m, b_m, d_m;

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({bram_en, bram_addr, m_valid, m_data, m_last, busy, done}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_ready = 1'b1;

        // Basic timing: addr 0, len 4, m_ready held high.
        start_burst(0, 4);
        capture(10, en_m, v_m, b_m, d_m);
        check("t1_en_cycles",    32'(en_m), 32'h001E);
`ifdef BRAM_OUTREG_EN
        check("t1_valid_cycles", 32'(v_m), 32'h00F0);
        check("t1_busy_cycles",  32'(b_m), 32'h00FE);
        check("t1_done_cycles",  32'(d_m), 32'h0100);
`else
        check("t1_valid_cycles", 32'(v_m), 32'h0078);
        check("t1_busy_cycles",  32'(b_m), 32'h007E);
        check("t1_done_cycles",  32'(d_m), 32'h0080);
`endif
        check("t1_beats_left", 32'(exp_beat_q.size()), 32'd0);

        // Address wrap at the top of the BRAM.
        run_burst("wrap4", 1022, 4, 32'hFFFF_FFFF, 0, 4 + 2 + TB_RD_LAT);
        run_burst("wrap8", 1020, 8, 32'hFFFF_FFFF, 0, 8 + 2 + TB_RD_LAT);

        // Backpressure: 8 stalled cycles first, then a mixed pattern.
        max_out = 0;
        run_burst("bp16", 300, 16, 32'hA5C3_9600, 0, 0);
        check("bp16_max_outstanding", 32'(max_out), 32'(TB_D));

        // start re-asserted mid-burst with another address must be ignored.
        run_burst("poke", 100, 6, 32'hFFFF_FFFF, 2, 6 + 2 + TB_RD_LAT);

        // Full-depth burst.
        run_burst("full", 5, 1024, 32'hFFFF_FFFF, 0, 1024 + 2 + TB_RD_LAT);

        // Zero-length burst.
        start_burst(7, 0);
        capture(6, en_m, v_m, b_m, d_m);
        check("len0_done_cycles", 32'(d_m), 32'h0002);
        check("len0_activity",    32'(en_m | v_m | b_m), 32'd0);

        // Reset in the middle of a burst.
        start_burst(40, 8);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", 32'({bram_en, bram_addr, m_valid, m_data, m_last, busy, done}), 32'd0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        capture(10, en_m, v_m, b_m, d_m);
        check("abort_no_activity", 32'(en_m | v_m | b_m | d_m), 32'd0);
        run_burst("recover", 200, 3, 32'hFFFF_FFFF, 0, 3 + 2 + TB_RD_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_bram_reader.md
# pool_bram_reader

Read-side sequencer for the pooling line buffer BRAM. On a start request it issues a contiguous burst of BRAM reads, absorbs the fixed BRAM read latency, and streams the returned words downstream on a valid/ready interface without loss under backpressure. It is the consumer counterpart of the write-address counter that fills the same BRAM.

## Interface
- SRAM_DEPTH, 1024: BRAM words; must be a power of two. AW = $clog2(SRAM_DEPTH).
- DATA_WIDTH, 8: BRAM word width.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- start_addr  in  AW  first BRAM address of the burst.
- len  in  AW+1  words to read, 0..SRAM_DEPTH.
- bram_en  out  1  read enable to BRAM port.
- bram_addr  out  AW  read address.
- bram_rdata  in  DATA_WIDTH  BRAM read data, valid RD_LAT cycles after bram_en.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  marks final word of burst.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- Reset values: bram_en=0, bram_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FSM=IDLE; FIFO empty; in-flight tracking cleared. Reset mid-burst aborts it; returning BRAM data is discarded.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start=1 and len>0 -> READ, latch start_addr, remaining=len, busy=1. start=1, len=0 -> stay IDLE, done pulses next cycle, no beats.
  - READ: issue reads per credit rule; after last issue -> DRAIN.
  - DRAIN: wait until final beat handshakes (m_valid & m_ready & m_last) -> IDLE, done=1, busy=0 in that following cycle.
- start while busy is ignored.
- Output FIFO depth D = RD_LAT+2. Read issued in a cycle iff remaining>0 and inflight+fifo_count < D (registered values). Guarantees no overflow under any m_ready pattern.
- Address advances by 1 per issued read, modulo SRAM_DEPTH: start_addr=1020, len=8 reads 1020..1023, 0..3.
- bram_en is low whenever no read is issued; bram_addr holds its last value.
- m_data/m_last stable while m_valid=1 and m_ready=0. m_last=1 only on word number len.
- Word order out equals address order; no drop, no duplication.

## Timing
- RD_LAT = 1 (default).
- Start sampled at edge E0; first bram_en in cycle after E0 (cycle 1); data captured into FIFO end of cycle 1+RD_LAT; first m_valid in cycle 2+RD_LAT (cycle 3 default).
- With m_ready held 1: one word per cycle sustained; burst of N completes last beat in cycle N+2+RD_LAT-1; done in following cycle.
- m_ready deasserted: issue stalls after at most D outstanding words; resumes the cycle after a pop frees a credit.

## Configuration
- BRAM_OUTREG_EN: defined -> BRAM output register enabled, RD_LAT=2, FIFO depth 4, first m_valid in cycle 4. Undefined -> RD_LAT=1, depth 3. All other behaviour identical.

## Structure
- Shared pool_pkg: FSM state enum (IDLE/READ/DRAIN), RD_LAT and FIFO depth constants selected by BRAM_OUTREG_EN.
- One sub-module pool_rd_fifo: register FIFO, parameterized width/depth, push/pop/count/full/empty; head entry drives m_data/m_last directly.
- In-flight tracking: RD_LAT-deep valid/last shift register in the top.

## Test plan
- Reset then start_addr=0, len=4, BRAM[i]=i+16, m_ready=1 -> m_data 16,17,18,19 on cycles 3..6, m_last on 19, done cycle 7, busy 1..6.
- Wrap: start_addr=1022, len=4 -> bram_addr 1022,1023,0,1; data order matches.
- Backpressure: len=16, m_ready random 50% -> all 16 words in order, never more than 3 outstanding, m_data stable while stalled.
- len=0 -> no bram_en, no m_valid, done one cycle after start, busy stays 0.
- start re-asserted mid-burst with different addr -> ignored; rst low mid-burst -> all outputs 0 next cycle, no stale beats after release.
- BRAM_OUTREG_EN defined, len=4, m_ready=1 -> first m_valid cycle 4, one word/cycle, depth-4 bound under stall.
